// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module : serial_subtractor
// Brief  : Bit-serial unsigned subtractor (a_in - b_in), LSB first, one bit per
//          clock via a single full-subtractor cell and a borrow flop, with a
//          start/done handshake. Define SERIAL_SUB_SAT_EN to clamp underflowing
//          results to zero.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             w_d;
  logic             w_br;
  logic [WIDTH-1:0] w_d_sr_next;

  // Full-subtractor cell on the current LSBs
  assign w_d         = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign w_br        = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign w_d_sr_next = {w_d, d_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          d_sr_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
        end
      end
      S_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = w_d_sr_next;
        br_d   = w_br;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d  = S_DONE;
          borrow_d = w_br;
`ifdef SERIAL_SUB_SAT_EN
          diff_d   = w_br ? '0 : w_d_sr_next;
`else
          diff_d   = w_d_sr_next;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module : tb_serial_subtractor
// Brief  : Self-checking bench for serial_subtractor (WIDTH=8) against an
//          arithmetic reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_checks;
  int n_errors;

  // Model of the held output registers
  logic [WIDTH-1:0] m_diff;
  logic             m_borrow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned r;
    r = (int'(a) - int'(b) + (1 << WIDTH)) % (1 << WIDTH);
`ifdef SERIAL_SUB_SAT_EN
    if (a < b) r = 0;
`endif
    return WIDTH'(r);
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b);
  endfunction

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
  endtask

  // Follows an accepted operation to completion; optionally pokes start mid-SHIFT.
  task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk);
      #1;
      if (poke && k == 3) begin
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (k < WIDTH) begin
        check("busy_shift", busy, 1);
        check("done_early", done, 0);
        check("diff_stable", diff, m_diff);
        check("borrow_stable", borrow, m_borrow);
      end
    end
    m_diff   = ref_diff(a, b);
    m_borrow = ref_borrow(a, b);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("diff", diff, m_diff);
    check("borrow", borrow, m_borrow);
    @(posedge clk);
    #1;
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("diff_hold", diff, m_diff);
    check("borrow_hold", borrow, m_borrow);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
    launch(a, b);
    finish_op(a, b, poke);
  endtask

  initial begin
    int t;
    int t_first;
    int n_done;
    logic [WIDTH-1:0] ra, rb;

    n_checks = 0;
    n_errors = 0;
    m_diff   = '0;
    m_borrow = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'h5A, 8'h3C, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0);
    do_op(8'hFF, 8'h00, 1'b0);
    do_op(8'h00, 8'hFF, 1'b0);
    do_op(8'h10, 8'h01, 1'b1);

    // Reset in the middle of SHIFT
    launch(8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_diff   = '0;
    m_borrow = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(posedge clk);
      #1;
      check("no_done_after_rst", done, 0);
    end
    do_op(8'h09, 8'h03, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    a_in  = 8'h80;
    b_in  = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in    = 8'h01;
    b_in    = 8'h02;
    n_done  = 0;
    t_first = 0;
    for (t = 1; t <= 40 && n_done < 2; t++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          t_first = t;
          check("b2b_lat1", t, WIDTH);
          check("b2b_diff1", diff, ref_diff(8'h80, 8'h01));
          check("b2b_borrow1", borrow, ref_borrow(8'h80, 8'h01));
        end else begin
          start = 1'b0;
          check("b2b_spacing", t - t_first, WIDTH + 2);
          check("b2b_diff2", diff, ref_diff(8'h01, 8'h02));
          check("b2b_borrow2", borrow, ref_borrow(8'h01, 8'h02));
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", n_done, 2);
    m_diff   = ref_diff(8'h01, 8'h02);
    m_borrow = ref_borrow(8'h01, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle", busy, 0);

    // Randomized operations, occasionally poking start mid-operation
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 7 == 0) rb = ra;
      do_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
